// File: rtl/elm_argmax_classifier.sv
// ---------------------------------------------------------------------------
// elm_argmax_classifier
//   Final stage of the ELM digit recognizer. Takes N_CLASSES signed scores,
//   one per handshake and in class order. It tracks the running maximum and
//   reports the winning class index when the frame completes.
//
//   Ports
//     clk_i          rising-edge clock
//     rst_ni         asynchronous active-low reset (aborts any frame)
//     start_i        begin a new frame (only honoured in IDLE)
//     score_in_i     signed score for the current class
//     score_valid_i  score_in_i valid this cycle
//     score_ready_o  high only in COLLECT
//     digit_o        winning class of the last completed frame
//     max_score_o    score of the winning class
//     done_o         one-cycle pulse when digit_o/max_score_o update
//     busy_o         high in COLLECT or DONE
//     margin_o       best minus second-best, unsigned (CLASSIFY_MARGIN_EN only)
//
//   Optional feature macro: CLASSIFY_MARGIN_EN
// ---------------------------------------------------------------------------
module elm_argmax_classifier #(
    parameter int N_CLASSES = 10,
    parameter int W         = 16,
    parameter int IDXW      = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [W-1:0]    score_in_i,
    input  logic            score_valid_i,
    output logic            score_ready_o,
    output logic [IDXW-1:0] digit_o,
    output logic [W-1:0]    max_score_o,
    output logic            done_o,
`ifdef CLASSIFY_MARGIN_EN
    output logic [W-1:0]    margin_o,
`endif
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    best_q, best_d;
    logic [IDXW-1:0] best_idx_q, best_idx_d;
    logic [IDXW-1:0] digit_q, digit_d;
    logic [W-1:0]    max_q, max_d;

    logic accept, last, new_best;

    assign accept   = score_valid_i && (state_q == S_COLLECT);
    assign last     = (idx_q == IDXW'(N_CLASSES - 1));
    // First score always seeds; afterwards strictly greater so ties keep the lower index.
    assign new_best = (idx_q == '0) || ($signed(score_in_i) > $signed(best_q));

`ifdef CLASSIFY_MARGIN_EN
    logic [W-1:0] second_q, second_d;
    logic [W-1:0] margin_q, margin_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        digit_d    = digit_q;
        max_d      = max_q;
`ifdef CLASSIFY_MARGIN_EN
        second_d   = second_q;
        margin_d   = margin_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COLLECT;
                    idx_d   = '0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    idx_d = idx_q + IDXW'(1);
                    if (new_best) begin
                        best_d     = score_in_i;
                        best_idx_d = idx_q;
                    end
`ifdef CLASSIFY_MARGIN_EN
                    // A displaced best becomes second; a tie with best is a
                    // second-best candidate. idx 1 always seeds second.
                    if (new_best)
                        second_d = best_q;
                    else if ((idx_q == IDXW'(1)) || ($signed(score_in_i) > $signed(second_q)))
                        second_d = score_in_i;
`endif
                    // Results are loaded on the final accept edge so they are
                    // already valid during the DONE cycle that pulses done_o.
                    if (last) begin
                        state_d = S_DONE;
                        digit_d = best_idx_d;
                        max_d   = best_d;
`ifdef CLASSIFY_MARGIN_EN
                        margin_d = best_d - second_d;
`endif
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            digit_q    <= '0;
            max_q      <= '0;
`ifdef CLASSIFY_MARGIN_EN
            second_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            digit_q    <= digit_d;
            max_q      <= max_d;
`ifdef CLASSIFY_MARGIN_EN
            second_q   <= second_d;
            margin_q   <= margin_d;
`endif
        end
    end

    assign score_ready_o = (state_q == S_COLLECT);
    assign done_o        = (state_q == S_DONE);
    assign busy_o        = (state_q != S_IDLE);
    assign digit_o       = digit_q;
    assign max_score_o   = max_q;
`ifdef CLASSIFY_MARGIN_EN
    assign margin_o      = margin_q;
`endif

endmodule

// File: tb/tb_elm_argmax_classifier.sv
// ---------------------------------------------------------------------------
// tb_elm_argmax_classifier
//   Scoreboard bench: each frame pushes its expected result (argmax computed
//   from the whole score list), and a monitor pops and compares on every done.
// ---------------------------------------------------------------------------
module tb_elm_argmax_classifier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] score;
    logic        valid;
    logic        ready;
    logic [3:0]  digit;
    logic [15:0] max_score;
    logic        done;
    logic        busy;
`ifdef CLASSIFY_MARGIN_EN
    logic [15:0] margin;
`endif

    always #5 clk = ~clk;

    elm_argmax_classifier #(.N_CLASSES(10), .W(16), .IDXW(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .score_in_i    (score),
        .score_valid_i (valid),
        .score_ready_o (ready),
        .digit_o       (digit),
        .max_score_o   (max_score),
        .done_o        (done),
`ifdef CLASSIFY_MARGIN_EN
        .margin_o      (margin),
`endif
        .busy_o        (busy)
    );

    typedef struct packed {
        logic [3:0]  digit;
        logic [15:0] maxs;
        logic [15:0] marg;
    } exp_t;

    exp_t               sb[$];
    logic signed [15:0] frame_sc [10];
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 n_frames = 0;
    int                 n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: first index holding the maximum; second-best is the largest
    // of the remaining scores (so a duplicate maximum gives margin 0).
    function automatic exp_t model();
        exp_t e;
        int bi = 0;
        int sec;
        int m;
        for (int i = 1; i < 10; i++)
            if (frame_sc[i] > frame_sc[bi]) bi = i;
        sec = -100000;
        for (int i = 0; i < 10; i++)
            if (i != bi && int'(frame_sc[i]) > sec) sec = int'(frame_sc[i]);
        m = int'(frame_sc[bi]) - sec;
        e.digit = 4'(bi);
        e.maxs  = frame_sc[bi];
        e.marg  = m[15:0];
        return e;
    endfunction

    // gap_mode: 0 continuous, 1 pattern 1,0,0, 2 random
    task automatic run_frame(input int gap_mode, input bit start_with_valid, input bit poke_start);
        int acc = 0;
        int cyc = 0;
        bit r, v;
        sb.push_back(model());
        n_frames++;
        if (!start_with_valid) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end else begin
            start = 1'b1;
        end
        while (acc < 10 && cyc < 300) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 3 == 0);
                default: v = ($urandom_range(0, 2) == 0);
            endcase
            valid = v;
            score = frame_sc[acc];
            if (poke_start && acc == 5) start = 1'b1;
            r = ready;
            if (start_with_valid && cyc == 0) chk("ready_in_start_cycle", 32'(r), 0);
            tick();
            start = 1'b0;
            cyc++;
            if (r && v) acc++;
        end
        valid = 1'b0;
        chk("accept_count", acc, 10);
        if (acc == 10) begin
            chk("done_latency", 32'(done), 1);
            chk("busy_in_done", 32'(busy), 1);
            tick();
            chk("done_one_cycle", 32'(done), 0);
            chk("busy_after", 32'(busy), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        score = '0;

        fork
            forever begin
                @(negedge clk);
                if (done === 1'b1) begin
                    n_done++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_done: got done=1 expected no pulse at %0t", $time);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("digit", 32'(digit), 32'(e.digit));
                        chk("max_score", 32'(max_score), 32'(e.maxs));
`ifdef CLASSIFY_MARGIN_EN
                        chk("margin", 32'(margin), 32'(e.marg));
`endif
                    end
                end
            end
        join_none

        // Reset state
        #1;
        chk("rst_digit", 32'(digit), 0);
        chk("rst_max", 32'(max_score), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
`ifdef CLASSIFY_MARGIN_EN
        chk("rst_margin", 32'(margin), 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();

        // Basic frame
        begin
            int bas[10] = '{5, -3, 40, 7, 12, 0, -100, 39, 1, 2};
            for (int i = 0; i < 10; i++) frame_sc[i] = 16'(bas[i]);
        end
        run_frame(0, 1'b0, 1'b0);
        chk("basic_digit", 32'(digit), 2);
        chk("basic_max", 32'(max_score), 40);
        repeat (2) tick();
        chk("digit_holds", 32'(digit), 2);

        // Reset mid-frame after 4 accepts
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            score = 16'($urandom);
            tick();
        end
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_digit", 32'(digit), 0);
        chk("midrst_max", 32'(max_score), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_stays_idle", 32'(busy), 0);

        // Tie: idx3 and idx8 both 25
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'sd0;
        frame_sc[3] = 16'sd25;
        frame_sc[8] = 16'sd25;
        run_frame(0, 1'b0, 1'b0);

        // Negative extremes
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'sh8000;
        run_frame(0, 1'b0, 1'b0);
        chk("neg_max", 32'(max_score), 32'h8000);
        for (int i = 0; i < 10; i++) frame_sc[i] = -16'sd1;
        frame_sc[9] = -16'sd2;
        run_frame(0, 1'b0, 1'b0);

        // Handshake gaps with a start pulse during COLLECT
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'($urandom);
        run_frame(1, 1'b0, 1'b1);
        repeat (3) tick();
        chk("ignored_start_idle", 32'(busy), 0);

        // IDLE guard: valid without start
        valid = 1'b1;
        score = 16'h7fff;
        for (int i = 0; i < 20; i++) begin
            chk("idle_ready", 32'(ready), 0);
            chk("idle_busy", 32'(busy), 0);
            tick();
        end
        valid = 1'b0;

        // start together with valid in IDLE
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'($urandom_range(0, 200)) - 16'sd100;
        run_frame(0, 1'b1, 1'b0);

        // Randomized frames, some with narrow ranges to provoke ties
        for (int f = 0; f < 30; f++) begin
            bit narrow = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 10; i++)
                frame_sc[i] = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom);
            run_frame(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_count", n_done, n_frames);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
